// File: rtl/serial_seq_detector_if.sv
// Bundle between a serial bit source and serial_seq_detector.
//   din, din_valid, clr_cnt : source -> detector (bit, accept strobe, counter clear)
//   match, match_count      : detector -> source (one-cycle hit pulse, saturating hit count)
//   window, filled          : detector -> source (shift window, window-eligible flag)
interface serial_seq_detector_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 4
);
  logic             din;
  logic             din_valid;
  logic             clr_cnt;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic [N-1:0]     window;
  logic             filled;

  modport master (
    output din, din_valid, clr_cnt,
    input  match, match_count, window, filled
  );

  modport slave (
    input  din, din_valid, clr_cnt,
    output match, match_count, window, filled
  );
endinterface

// File: rtl/serial_seq_detector.sv
// Serial sequence detector: shifts accepted bits into an N-bit window, pulses match for one
// cycle when the window equals PATTERN, and keeps a saturating count of matches.
// Ports:
//   i_clk  : clock, all state on rising edge
//   i_rst  : synchronous active-high reset
//   io_sd  : slave side of serial_seq_detector_if (din/din_valid/clr_cnt in;
//            match/match_count/window/filled out)
module serial_seq_detector #(
  parameter int unsigned  N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1011,
  parameter bit           OVERLAP = 1'b1,
  parameter int unsigned  CNT_W   = 4
) (
  input logic                  i_clk,
  input logic                  i_rst,
  serial_seq_detector_if.slave io_sd
);

  localparam int unsigned FW = $clog2(N + 1);
  localparam logic [FW-1:0] FillMax = FW'(N);

  // FILL/ARMED is fully determined by the fill counter; the enum names it.
  typedef enum logic {StFill, StArmed} state_e;

  logic [N-1:0]     r_window, w_window_d;
  logic [FW-1:0]    r_fill, w_fill_d;
  logic             r_match, w_match_d;
  logic [CNT_W-1:0] r_count, w_count_d;

  state_e           w_state;
  logic [N-1:0]     w_shift;
  logic [FW-1:0]    w_next_fill;
  logic             w_hit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_window <= '0;
      r_fill   <= '0;
      r_match  <= 1'b0;
      r_count  <= '0;
    end else begin
      r_window <= w_window_d;
      r_fill   <= w_fill_d;
      r_match  <= w_match_d;
      r_count  <= w_count_d;
    end
  end

  always_comb begin
    w_state     = (r_fill == FillMax) ? StArmed : StFill;
    w_shift     = {r_window[N-2:0], io_sd.din};
    w_next_fill = (w_state == StArmed) ? FillMax : r_fill + FW'(1);
    // A hit needs N accepted bits since reset/last non-overlap hit, so the zeroed
    // reset window can never alias an all-zero pattern.
    w_hit       = io_sd.din_valid && (w_next_fill == FillMax) && (w_shift == PATTERN);

    w_window_d  = r_window;
    w_fill_d    = r_fill;
    w_match_d   = w_hit;
    w_count_d   = r_count;

    if (io_sd.din_valid) begin
      w_window_d = w_shift;
      // Non-overlap: restart filling but keep window bits for observation.
      w_fill_d   = (w_hit && !OVERLAP) ? '0 : w_next_fill;
    end

    if (io_sd.clr_cnt) begin
      w_count_d = w_hit ? CNT_W'(1) : '0;
    end else if (w_hit && (r_count != '1)) begin
      w_count_d = r_count + CNT_W'(1);
    end
  end

  assign io_sd.match       = r_match;
  assign io_sd.match_count = r_count;
  assign io_sd.window      = r_window;
  assign io_sd.filled      = (w_state == StArmed);

endmodule

// File: tb/tb_serial_seq_detector.sv
// Self-checking bench for serial_seq_detector: three instances share one stimulus stream
// (PATTERN=1011 overlapping, PATTERN=1011 non-overlapping, PATTERN=0000 overlapping).
module tb_serial_seq_detector;

  logic clk = 1'b0;
  logic rst;
  logic d_din, d_vld, d_clr;

  always #5 clk = ~clk;

  serial_seq_detector_if #(.N(4), .CNT_W(4)) if_ov ();
  serial_seq_detector_if #(.N(4), .CNT_W(4)) if_nov ();
  serial_seq_detector_if #(.N(4), .CNT_W(4)) if_z ();

  assign if_ov.din        = d_din;
  assign if_ov.din_valid  = d_vld;
  assign if_ov.clr_cnt    = d_clr;
  assign if_nov.din       = d_din;
  assign if_nov.din_valid = d_vld;
  assign if_nov.clr_cnt   = d_clr;
  assign if_z.din         = d_din;
  assign if_z.din_valid   = d_vld;
  assign if_z.clr_cnt     = d_clr;

  serial_seq_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(4)) u_ov (
    .i_clk (clk),
    .i_rst (rst),
    .io_sd (if_ov)
  );

  serial_seq_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(4)) u_nov (
    .i_clk (clk),
    .i_rst (rst),
    .io_sd (if_nov)
  );

  serial_seq_detector #(.N(4), .PATTERN(4'b0000), .OVERLAP(1'b1), .CNT_W(4)) u_z (
    .i_clk (clk),
    .i_rst (rst),
    .io_sd (if_z)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic tick(input logic r, input logic d, input logic v, input logic c);
    rst   = r;
    d_din = d;
    d_vld = v;
    d_clr = c;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst, din, vld, clr;
    logic [3:0] win;
    logic       om;
    logic [3:0] oc;
    logic       of;
    logic       nm;
    logic [3:0] nc;
    logic       nf;
  } vec_t;

  vec_t vecs[22];
  logic [3:0] pat;
  int e;

  initial begin
    rst = 1'b1; d_din = 1'b0; d_vld = 1'b0; d_clr = 1'b0;
    @(posedge clk);
    #1;

    // rst din vld clr | window | ov: match cnt filled | nov: match cnt filled
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b0101, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b1011, 1'b1, 4'd1, 1'b1, 1'b1, 4'd1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0110, 1'b0, 4'd1, 1'b1, 1'b0, 4'd1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b1101, 1'b0, 4'd1, 1'b1, 1'b0, 4'd1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b1011, 1'b1, 4'd2, 1'b1, 1'b0, 4'd1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b0111, 1'b0, 4'd2, 1'b1, 1'b0, 4'd1, 1'b1};
    // reset wins over din_valid, then 1,0,1,1 with gaps of 1,2,3 invalid cycles
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b0101, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0101, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0101, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0101, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b1011, 1'b1, 4'd1, 1'b1, 1'b1, 4'd1, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b0, 4'd1, 1'b1, 1'b0, 4'd1, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0};

    for (int i = 0; i < 22; i++) begin
      tick(vecs[i].rst, vecs[i].din, vecs[i].vld, vecs[i].clr);
      chk($sformatf("v%0d ov_window", i), 32'(if_ov.window), 32'(vecs[i].win));
      chk($sformatf("v%0d ov_match", i), 32'(if_ov.match), 32'(vecs[i].om));
      chk($sformatf("v%0d ov_count", i), 32'(if_ov.match_count), 32'(vecs[i].oc));
      chk($sformatf("v%0d ov_filled", i), 32'(if_ov.filled), 32'(vecs[i].of));
      chk($sformatf("v%0d nov_window", i), 32'(if_nov.window), 32'(vecs[i].win));
      chk($sformatf("v%0d nov_match", i), 32'(if_nov.match), 32'(vecs[i].nm));
      chk($sformatf("v%0d nov_count", i), 32'(if_nov.match_count), 32'(vecs[i].nc));
      chk($sformatf("v%0d nov_filled", i), 32'(if_nov.filled), 32'(vecs[i].nf));
    end

    // Twenty back-to-back 1011 occurrences: counter saturates at 15, match keeps pulsing.
    pat = 4'b1011;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      for (int j = 0; j < 4; j++) begin
        tick(1'b0, pat[3-j], 1'b1, 1'b0);
        chk($sformatf("sat k%0d j%0d match", k, j), 32'(if_ov.match), (j == 3) ? 32'd1 : 32'd0);
        if (j == 3) begin
          e = (k < 15) ? k : 15;
          chk($sformatf("sat k%0d count", k), 32'(if_ov.match_count), 32'(e));
        end
      end
    end

    // Clear alone, rebuild to 5, then clear on the edge of a match.
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_alone count", 32'(if_ov.match_count), 32'd0);
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 4; j++) tick(1'b0, pat[3-j], 1'b1, 1'b0);
    end
    chk("rebuild count", 32'(if_ov.match_count), 32'd5);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    chk("clr_hit match", 32'(if_ov.match), 32'd1);
    chk("clr_hit count", 32'(if_ov.match_count), 32'd1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_after count", 32'(if_ov.match_count), 32'd0);
    chk("clr_after match", 32'(if_ov.match), 32'd0);

    // Reset mid-sequence discards 1,0,1; the following 1 must not complete a match.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    chk("midrst match", 32'(if_ov.match), 32'd0);
    chk("midrst window", 32'(if_ov.window), 32'h1);
    chk("midrst filled", 32'(if_ov.filled), 32'd0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    chk("midrst refill match", 32'(if_ov.match), 32'd1);
    chk("midrst refill count", 32'(if_ov.match_count), 32'd1);

    // All-zero pattern must not fire on the zeroed reset window.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("zero reset filled", 32'(if_z.filled), 32'd0);
    for (int j = 0; j < 3; j++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("zero j%0d match", j), 32'(if_z.match), 32'd0);
      chk($sformatf("zero j%0d filled", j), 32'(if_z.filled), 32'd0);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("zero 4th match", 32'(if_z.match), 32'd1);
    chk("zero 4th count", 32'(if_z.match_count), 32'd1);
    chk("zero 4th filled", 32'(if_z.filled), 32'd1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("zero pulse drop", 32'(if_z.match), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
